uart_receiver: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_tick_gen.sv | 33 +++
 rtl/uart_receiver.sv | 119 +++++++++++
 tb/tb_uart_receiver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
//==== uart_pkg -- shared types and helpers for the UART blocks ==== rev 1.0
`default_nettype none

package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  // Sysclk cycles per oversample tick, never below one.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int d;
    d = clk_freq / (baud * oversample);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tick_gen.sv
//==== uart_tick_gen -- oversample tick divider with phase restart ==== rev 1.0
`default_nettype none

module uart_tick_gen #(
  parameter int DIV = 10
) (
  input  logic sysclk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Suppressed on restart so the first tick lands a full DIV after the edge.
  assign tick = (cnt == LAST) && !restart;

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
//==== uart_receiver -- 8N1 receive path with optional data-bit inversion ==== rev 1.0
`default_nettype none

module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_INV   = 1
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       enable,
  input  logic       UART_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_STATUS,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int MID = OVERSAMPLE / 2;
  localparam int TCW = $clog2(OVERSAMPLE);
  localparam logic [TCW-1:0] TC_LAST = TCW'(OVERSAMPLE - 1);
  localparam logic [TCW-1:0] TC_S0   = TCW'(MID - 1);
  localparam logic [TCW-1:0] TC_S1   = TCW'(MID);
  localparam logic [TCW-1:0] TC_S2   = TCW'(MID + 1);
  localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);

  state_t         state;
  logic           sync1, rx_s, rx_prev;
  logic [TCW-1:0] tc, tc_nx;
  logic [2:0]     bit_cnt;
  logic [7:0]     shift;
  logic           s_a, s_b;
  logic           tick, restart, falling, bit_maj;

  assign falling = rx_prev & ~rx_s;
  assign restart = (state == IDLE) && enable && falling;
  assign tc_nx   = (tc == TC_LAST) ? '0 : tc + 1'b1;
  assign bit_maj = maj3(s_a, s_b, rx_s);
  assign busy    = (state != IDLE);

  uart_tick_gen #(.DIV(DIV)) u_tick (
    .sysclk (sysclk),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge sysclk) begin
    if (!reset) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev   <= 1'b1;
      state     <= IDLE;
      tc        <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      s_a       <= 1'b0;
      s_b       <= 1'b0;
      RX_DATA   <= 8'h00;
      RX_STATUS <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1     <= UART_RX;
      rx_s      <= sync1;
      rx_prev   <= rx_s;
      RX_STATUS <= 1'b0;
      frame_err <= 1'b0;
      if (!enable) begin
        state <= IDLE;
      end else if (state == IDLE) begin
        if (falling) begin
          state <= START;
          tc    <= '0;
        end
      end else if (tick) begin
        tc <= tc_nx;
        if (tc_nx == TC_S0) s_a <= rx_s;
        if (tc_nx == TC_S1) s_b <= rx_s;
        case (state)
          START: begin
            // Two high samples already outvote the third: treat as a glitch.
            if (tc_nx == TC_S1 && s_a && rx_s) begin
              state <= IDLE;
            end else if (tc_nx == '0) begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            if (tc_nx == TC_S2) shift <= {bit_maj, shift[7:1]};
            if (tc_nx == '0) begin
              if (bit_cnt == LAST_BIT) state <= STOP;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tc_nx == TC_S2) begin
              state <= IDLE;
              if (bit_maj) begin
                RX_DATA   <= (DATA_INV != 0) ? ~shift : shift;
                RX_STATUS <= 1'b1;
              end else begin
                frame_err <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
//==== tb_uart_receiver -- directed self-checking bench for uart_receiver ==== rev 1.0
`default_nettype none

module tb_uart_receiver;

  localparam int BIT = 160;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rx_inv, rx_true;
  logic [7:0] data_inv, data_true;
  logic       st_inv, st_true, fe_inv, fe_true, busy_inv, busy_true;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stat_cnt = 0;
  int tstat_cnt = 0;
  int ferr_cnt = 0;
  int both_hi = 0;
  int start_cyc = 0;
  logic [7:0] dq[$];
  int tq[$];

  always #5 clk = ~clk;

  uart_receiver #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_INV(1)) dut_inv (
    .sysclk(clk), .reset(rst_n), .enable(en), .UART_RX(rx_inv),
    .RX_DATA(data_inv), .RX_STATUS(st_inv), .frame_err(fe_inv), .busy(busy_inv)
  );

  uart_receiver #(.CLK_FREQ(1_600_000), .BAUD(10_000), .OVERSAMPLE(16), .DATA_INV(0)) dut_true (
    .sysclk(clk), .reset(rst_n), .enable(en), .UART_RX(rx_true),
    .RX_DATA(data_true), .RX_STATUS(st_true), .frame_err(fe_true), .busy(busy_true)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (st_inv) begin
      dq.push_back(data_inv);
      tq.push_back(cyc);
      stat_cnt <= stat_cnt + 1;
    end
    if (fe_inv) ferr_cnt <= ferr_cnt + 1;
    if (st_inv && fe_inv) both_hi <= both_hi + 1;
    if (st_true) tstat_cnt <= tstat_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit on_true, input logic v);
    if (on_true) rx_true = v;
    else rx_inv = v;
  endtask

  // Full frame; on the inverting line the data bits are complemented.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit on_true);
    start_cyc = cyc;
    drive(on_true, 1'b0);
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      drive(on_true, on_true ? b[i] : ~b[i]);
      idle(BIT);
    end
    drive(on_true, stop_bit);
    idle(BIT);
    drive(on_true, 1'b1);
  endtask

  // Start bit plus data bits 0..3, then half of bit 4.
  task automatic send_head_77();
    rx_inv = 1'b0;
    idle(BIT);
    for (int i = 0; i < 4; i++) begin
      rx_inv = ~(8'h77 >> i) & 1'b1;
      idle(BIT);
    end
    rx_inv = 1'b0;
    idle(BIT / 2);
  endtask

  function automatic logic [7:0] qd(input int i);
    return (dq.size() > i) ? dq[i] : 8'hxx;
  endfunction

  function automatic int qt(input int i);
    return (tq.size() > i) ? tq[i] : -100000;
  endfunction

  initial begin
    int n0, f0, t0, lat, g0;

    rst_n = 1'b0; en = 1'b1; rx_inv = 1'b1; rx_true = 1'b1;
    idle(1);
    for (int i = 0; i < 5; i++) begin
      rx_inv  = i[0];
      rx_true = ~i[0];
      idle(1);
    end
    chk("reset_data", {24'd0, data_inv}, 32'h00);
    chk("reset_status", {31'd0, st_inv}, 32'd0);
    chk("reset_ferr", {31'd0, fe_inv}, 32'd0);
    chk("reset_busy", {31'd0, busy_inv}, 32'd0);
    chk("reset_data_true", {24'd0, data_true}, 32'h00);
    rx_inv = 1'b1; rx_true = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(20);

    // Good frame, inverted line
    n0 = stat_cnt; f0 = ferr_cnt;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(20);
    chk("a5_count", stat_cnt, n0 + 1);
    chk("a5_data", {24'd0, data_inv}, 32'hA5);
    lat = qt(n0) - start_cyc;
    chk("a5_latency_window", {31'd0, (lat >= 1510 && lat <= 1560)}, 32'd1);
    chk("a5_no_ferr", ferr_cnt, f0);

    // Good frame, true-polarity instance
    t0 = tstat_cnt;
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(20);
    chk("true_a5_count", tstat_cnt, t0 + 1);
    chk("true_a5_data", {24'd0, data_true}, 32'hA5);

    // Glitch: 40 low cycles must not start a frame
    n0 = stat_cnt;
    rx_inv = 1'b0;
    idle(40);
    rx_inv = 1'b1;
    idle(45);
    chk("glitch_busy_low", {31'd0, busy_inv}, 32'd0);
    idle(200);
    chk("glitch_no_strobe", stat_cnt, n0);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(20);
    chk("post_glitch_count", stat_cnt, n0 + 1);
    chk("post_glitch_data", {24'd0, data_inv}, 32'h3C);

    // Framing error
    n0 = stat_cnt; f0 = ferr_cnt;
    send_frame(8'h5A, 1'b0, 1'b0);
    idle(50);
    chk("ferr_count", ferr_cnt, f0 + 1);
    chk("ferr_no_strobe", stat_cnt, n0);
    chk("ferr_data_held", {24'd0, data_inv}, 32'h3C);

    // Back-to-back frames with no idle gap
    n0 = stat_cnt;
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(20);
    chk("b2b_count", stat_cnt, n0 + 3);
    chk("b2b_data0", {24'd0, qd(n0)}, 32'h00);
    chk("b2b_data1", {24'd0, qd(n0 + 1)}, 32'hFF);
    chk("b2b_data2", {24'd0, qd(n0 + 2)}, 32'h81);
    chk("b2b_gap01", qt(n0 + 1) - qt(n0), 32'd1600);
    chk("b2b_gap12", qt(n0 + 2) - qt(n0 + 1), 32'd1600);

    // Abort by reset during data bit 4
    n0 = stat_cnt;
    send_head_77();
    rst_n = 1'b0;
    idle(10);
    rx_inv = 1'b1;
    idle(5);
    rst_n = 1'b1;
    idle(2000);
    chk("rst_abort_no_strobe", stat_cnt, n0);
    chk("rst_abort_data_cleared", {24'd0, data_inv}, 32'h00);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(20);
    chk("rst_abort_next_count", stat_cnt, n0 + 1);
    chk("rst_abort_next_data", {24'd0, data_inv}, 32'h12);

    // Abort by enable during data bit 4
    g0 = stat_cnt;
    send_head_77();
    en = 1'b0;
    idle(2);
    chk("en_abort_idle", {31'd0, busy_inv}, 32'd0);
    rx_inv = 1'b1;
    idle(1800);
    en = 1'b1;
    idle(20);
    chk("en_abort_no_strobe", stat_cnt, g0);
    chk("en_abort_data_held", {24'd0, data_inv}, 32'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    idle(20);
    chk("en_abort_next_count", stat_cnt, g0 + 1);
    chk("en_abort_next_data", {24'd0, data_inv}, 32'h12);

    chk("strobes_exclusive", both_hi, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
